data_memory_pipelined: RTL and testbench

Parametrised successor to the pipeline's single-cycle data memory, used by the MEM stage.
- Supports byte, half, word and (when DATA_WIDTH=64) double accesses using a byte address.
- Adds a configurable read latency with a valid/ready handshake, misalignment detection, and a debug read port for the debug unit.
- Single outstanding request. The MEM stage stalls while o_req_ready is low.

---
 rtl/data_memory_pipelined.sv | 144 ++++++++++++++
 tb/tb_data_memory_pipelined.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipelined.sv
// Byte-addressable data memory for the MEM stage: one outstanding request, configurable load latency, debug word port.
// States: IDLE = accepting requests and stores | WAIT = load latency countdown | RESP = load response cycle.
module data_memory_pipelined #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_mem_write,
  input  logic [1:0]                   i_mem_size,
  input  logic                         i_unsigned_op,
  input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0] i_byte_addr,
  input  logic [DATA_WIDTH-1:0]        i_write_data,
  output logic                         o_rsp_valid,
  output logic [DATA_WIDTH-1:0]        o_read_data,
  output logic                         o_error,
  input  logic                         i_dbg_en,
  input  logic [ADDR_WIDTH-1:0]        i_dbg_addr,
  output logic [DATA_WIDTH-1:0]        o_dbg_data
);
  localparam int BO    = $clog2(DATA_WIDTH/8);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dbg_data;
  logic                  r_store_rsp, r_store_err;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_load_err;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [BO-1:0]         w_off;
  logic [BO+2:0]         w_shamt;
  logic                  w_accept, w_err;
  logic [DATA_WIDTH-1:0] w_word, w_size_mask, w_wr_mask, w_wr_word, w_sh, w_ld_data;
  logic                  w_sign_bit;

  assign w_idx    = i_byte_addr[ADDR_WIDTH+BO-1:BO];
  assign w_off    = i_byte_addr[BO-1:0];
  assign w_shamt  = {w_off, 3'b000};
  assign w_word   = r_mem[w_idx];
  assign o_req_ready = (r_state == S_IDLE) && !i_dbg_en && !i_reset;
  assign w_accept = i_req_valid && o_req_ready;

  always_comb begin
    w_err       = 1'b0;
    w_size_mask = '1;
    w_sign_bit  = 1'b0;
    w_sh        = w_word >> w_shamt;
    case (i_mem_size)
      2'b00: begin
        w_size_mask = DATA_WIDTH'(8'hFF);
        w_sign_bit  = w_sh[7];
      end
      2'b01: begin
        w_err       = w_off[0];
        w_size_mask = DATA_WIDTH'(16'hFFFF);
        w_sign_bit  = w_sh[15];
      end
      2'b10: begin
        w_err       = (w_off[1:0] != 2'b00);
        w_size_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        w_sign_bit  = w_sh[31];
      end
      default: begin
        w_err       = (DATA_WIDTH != 64) || (w_off != '0);
        w_size_mask = '1;
        w_sign_bit  = w_sh[DATA_WIDTH-1];
      end
    endcase
    w_wr_mask = w_size_mask << w_shamt;
    w_wr_word = (w_word & ~w_wr_mask) | ((i_write_data & w_size_mask) << w_shamt);
    // Full-width fields have an all-ones mask, so both branches pass them through untouched.
    w_ld_data = (!i_unsigned_op && w_sign_bit) ? (w_sh | ~w_size_mask) : (w_sh & w_size_mask);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_dbg_data <= '0;
    end else begin
      if (w_accept && i_mem_write && !w_err) r_mem[w_idx] <= w_wr_word;
      if (i_dbg_en) r_dbg_data <= r_mem[i_dbg_addr];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_store_rsp <= 1'b0;
      r_store_err <= 1'b0;
      r_load_data <= '0;
      r_load_err  <= 1'b0;
    end else begin
      r_store_rsp <= w_accept && i_mem_write;
      if (w_accept && i_mem_write) r_store_err <= w_err;
      if (w_accept && !i_mem_write) begin
        r_load_data <= w_err ? '0 : w_ld_data;
        r_load_err  <= w_err;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !i_mem_write) begin
          w_cnt_nxt   = CW'(READ_LATENCY - 1);
          w_state_nxt = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_cnt_nxt == '0) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_rsp_valid = r_store_rsp || (r_state == S_RESP);
  assign o_read_data = (r_state == S_RESP) ? r_load_data : '0;
  assign o_error     = r_store_rsp ? r_store_err : ((r_state == S_RESP) && r_load_err);
  assign o_dbg_data  = r_dbg_data;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: directed scenarios plus random traffic against a byte-array reference model.
module tb_data_memory_pipelined;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int NB = (1 << AW) * 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_mem_write = 1'b0;
  logic [1:0]    i_mem_size = 2'b00;
  logic          i_unsigned_op = 1'b0;
  logic [AW+1:0] i_byte_addr = '0;
  logic [DW-1:0] i_write_data = '0;
  logic          o_rsp_valid;
  logic [DW-1:0] o_read_data;
  logic          o_error;
  logic          i_dbg_en = 1'b0;
  logic [AW-1:0] i_dbg_addr = '0;
  logic [DW-1:0] o_dbg_data;

  data_memory_pipelined #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_mem_write(i_mem_write), .i_mem_size(i_mem_size), .i_unsigned_op(i_unsigned_op),
    .i_byte_addr(i_byte_addr), .i_write_data(i_write_data), .o_rsp_valid(o_rsp_valid),
    .o_read_data(o_read_data), .o_error(o_error), .i_dbg_en(i_dbg_en),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] m_mem [NB];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [1:0] size, input int addr);
    int nb;
    nb = 1 << size;
    if (size == 2'd3) return 1'b1;
    return (addr % nb) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns, input int addr);
    int nb;
    logic [63:0] v;
    nb = 1 << size;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = m_mem[addr + i];
    if (!uns && v[8*nb-1])
      for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] size, input int addr, input logic [31:0] data);
    int nb;
    nb = 1 << size;
    for (int i = 0; i < nb; i++) m_mem[addr + i] = data[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;
  endtask

  // Called one time unit after a rising edge with the DUT idle.
  task automatic do_req(input bit wr, input logic [1:0] size, input bit uns, input int addr,
                        input logic [31:0] wdata);
    bit err;
    logic [31:0] exp_data;
    int lat;
    err      = model_err(size, addr);
    exp_data = (wr || err) ? 32'h0 : model_load(size, uns, addr);
    lat      = wr ? 1 : RL;
    i_req_valid   = 1'b1;
    i_mem_write   = wr;
    i_mem_size    = size;
    i_unsigned_op = uns;
    i_byte_addr   = addr[AW+1:0];
    i_write_data  = wdata;
    chk("ready_idle", o_req_ready, 1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    if (wr && !err) model_store(size, addr, wdata);
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        chk("rsp_early", o_rsp_valid, 0);
        chk("ready_busy", o_req_ready, 0);
        @(posedge i_clk); #1;
      end else begin
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_data", o_read_data, exp_data);
        chk("rsp_error", o_error, err);
        chk("ready_rsp", o_req_ready, wr);
      end
    end
    if (!wr) begin
      @(posedge i_clk); #1;
      chk("rsp_pulse", o_rsp_valid, 0);
      chk("ready_back", o_req_ready, 1);
    end
  endtask

  task automatic reset_dut();
    i_reset = 1'b1;
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_rsp", o_rsp_valid, 0);
    chk("rst_data", o_read_data, 0);
    chk("rst_err", o_error, 0);
    chk("rst_dbg", o_dbg_data, 0);
    i_reset = 1'b0;
    model_clear();
    #1;
    chk("ready_after_rst", o_req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr, uns;
    logic [1:0] size;
    int addr, r;

    model_clear();
    reset_dut();

    // Word store/load and latency
    do_req(1, 2'b10, 0, 'h010, 32'hDEADBEEF);
    do_req(0, 2'b10, 0, 'h010, 32'h0);

    // Debug port owns the memory; a pending request must not be taken
    i_dbg_addr = 9'd4;
    i_dbg_en = 1'b1;
    i_req_valid = 1'b1;
    i_mem_write = 1'b1;
    i_mem_size = 2'b10;
    i_byte_addr = 'h010;
    i_write_data = 32'h0;
    #1;
    chk("dbg_ready", o_req_ready, 0);
    @(posedge i_clk); #1;
    chk("dbg_data", o_dbg_data, 32'hDEADBEEF);
    chk("dbg_ready2", o_req_ready, 0);
    chk("dbg_no_rsp", o_rsp_valid, 0);
    @(posedge i_clk); #1;
    chk("dbg_no_rsp2", o_rsp_valid, 0);
    i_req_valid = 1'b0;
    i_dbg_en = 1'b0;
    i_dbg_addr = 9'd0;
    #1;
    chk("dbg_ready_back", o_req_ready, 1);
    @(posedge i_clk); #1;
    chk("dbg_hold", o_dbg_data, 32'hDEADBEEF);

    // Byte lanes and extension
    do_req(1, 2'b00, 0, 'h013, 32'h00000080);
    do_req(0, 2'b00, 0, 'h013, 32'h0);
    do_req(0, 2'b00, 1, 'h013, 32'h0);
    do_req(0, 2'b10, 0, 'h010, 32'h0);
    chk("byte_model", model_load(2'b10, 0, 'h010), 32'h80ADBEEF);

    do_req(1, 2'b01, 0, 'h022, 32'h00008001);
    do_req(0, 2'b01, 0, 'h022, 32'h0);
    do_req(0, 2'b01, 1, 'h022, 32'h0);
    do_req(0, 2'b01, 0, 'h020, 32'h0);

    // Misalignment and illegal size
    do_req(0, 2'b01, 0, 'h011, 32'h0);
    do_req(1, 2'b10, 0, 'h012, 32'h12345678);
    do_req(1, 2'b11, 0, 'h010, 32'h12345678);
    do_req(0, 2'b11, 0, 'h010, 32'h0);
    do_req(0, 2'b10, 1, 'h010, 32'h0);

    // Reset during WAIT: the aborted read never responds
    i_req_valid = 1'b1;
    i_mem_write = 1'b0;
    i_mem_size = 2'b10;
    i_byte_addr = 'h010;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk("abort_wait", o_rsp_valid, 0);
    i_reset = 1'b1;
    #1;
    chk("abort_ready", o_req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      chk("abort_in_rst", o_rsp_valid, 0);
    end
    i_reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      chk("abort_after_rst", o_rsp_valid, 0);
    end
    do_req(0, 2'b10, 0, 'h010, 32'h0);

    // Random traffic in a small window to get frequent overlap
    for (int n = 0; n < 400; n++) begin
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 9));
      size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      addr = int'($urandom_range(0, 127));
      if (size != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((1 << size) - 1);
      do_req(wr, size, uns, addr, $urandom);
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 31));
        i_dbg_addr = r[AW-1:0];
        i_dbg_en = 1'b1;
        @(posedge i_clk); #1;
        chk("rand_dbg", o_dbg_data, model_load(2'b10, 1, r * 4));
        i_dbg_en = 1'b0;
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
